// File: rtl/rf_pkg.sv
// Register-file write-port types shared by the write-back arbiter and its FIFO.
package rf_pkg;
  localparam int REG_W  = 5;
  localparam int DATA_W = 32;

  typedef struct packed {
    logic              valid;
    logic [REG_W-1:0]  wreg;
    logic [DATA_W-1:0] data;
  } wb_entry_t;
endpackage

// File: rtl/wb_fifo.sv
// Long-latency write-back buffer: DEPTH-entry ring with kill-by-register, 1-cycle push-to-head.
// Full blocks pushes regardless of a same-cycle pop; entries exported oldest-first for lookups.
module wb_fifo
  import rf_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_vld,
  input  wb_entry_t        push_dat,
  input  logic             pop_vld,
  input  logic             kill_vld,
  input  logic [REG_W-1:0] kill_reg,
  output logic             full,
  output logic             empty,
  output wb_entry_t        head_dat,
  output wb_entry_t        ent_dat [DEPTH]
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  wb_entry_t     mem_q [DEPTH];
  wb_entry_t     mem_d [DEPTH];
  logic [PW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          push_ok, pop_ok;

  assign full    = (cnt_q == CW'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign push_ok = push_vld && !full;
  assign pop_ok  = pop_vld && !empty;

  always_comb begin
    mem_d  = mem_q;
    head_d = head_q;
    tail_d = tail_q;
    // Killed entries keep their slot so ordering and occupancy stay intact.
    for (int i = 0; i < DEPTH; i++) begin
      if (kill_vld && mem_q[i].valid && mem_q[i].wreg == kill_reg) begin
        mem_d[i].valid = 1'b0;
      end
    end
    if (pop_ok) begin
      mem_d[head_q].valid = 1'b0;
      head_d              = head_q + PW'(1);
    end
    if (push_ok) begin
      mem_d[tail_q] = push_dat;
      tail_d        = tail_q + PW'(1);
    end
    cnt_d = cnt_q + CW'(push_ok) - CW'(pop_ok);
  end

  always_comb begin
    head_dat = mem_q[head_q];
    if (empty) head_dat.valid = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      ent_dat[i]       = mem_q[head_q + PW'(i)];
      ent_dat[i].valid = mem_q[head_q + PW'(i)].valid && (CW'(i) < cnt_q);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
    end else begin
      mem_q  <= mem_d;
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
    end
  end
endmodule

// File: rtl/wb_arbiter.sv
// Write-back arbiter: pipeline (1 cycle, always wins) and long-latency FIFO (>=2 cycles) share one RF port.
// lu_ready = !full; pend/forward are combinational. WB_FWD_EN adds the fwd_data1/fwd_data2 ports.
module wb_arbiter
  import rf_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pipe_valid,
  input  logic [REG_W-1:0]  pipe_reg,
  input  logic [DATA_W-1:0] pipe_data,
  input  logic              lu_valid,
  output logic              lu_ready,
  input  logic [REG_W-1:0]  lu_reg,
  input  logic [DATA_W-1:0] lu_data,
  output logic              RegWrite,
  output logic [REG_W-1:0]  WriteReg,
  output logic [DATA_W-1:0] WriteData,
  input  logic [REG_W-1:0]  q_reg1,
  input  logic [REG_W-1:0]  q_reg2,
  output logic              pend1,
  output logic              pend2
`ifdef WB_FWD_EN
  ,
  output logic [DATA_W-1:0] fwd_data1,
  output logic [DATA_W-1:0] fwd_data2
`endif
);
  logic              pipe_acc, lu_push, pop_vld, full, empty;
  wb_entry_t         push_dat, head_dat;
  wb_entry_t         ent_dat [DEPTH];
  logic              regwrite_q, regwrite_d;
  logic [REG_W-1:0]  wreg_q, wreg_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] fwd1, fwd2;

  assign pipe_acc = pipe_valid && (pipe_reg != '0);
  assign lu_ready = !full;
  assign lu_push  = lu_valid && (lu_reg != '0);

  // A same-cycle pipeline write to the same register makes the LU result stale on arrival.
  assign push_dat = '{valid: !(pipe_acc && pipe_reg == lu_reg), wreg: lu_reg, data: lu_data};

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push_vld (lu_push),
    .push_dat (push_dat),
    .pop_vld  (pop_vld),
    .kill_vld (pipe_acc),
    .kill_reg (pipe_reg),
    .full     (full),
    .empty    (empty),
    .head_dat (head_dat),
    .ent_dat  (ent_dat)
  );

  always_comb begin
    regwrite_d = 1'b0;
    wreg_d     = wreg_q;
    wdata_d    = wdata_q;
    pop_vld    = 1'b0;
    if (pipe_acc) begin
      regwrite_d = 1'b1;
      wreg_d     = pipe_reg;
      wdata_d    = pipe_data;
    end else if (!empty) begin
      pop_vld = 1'b1;
      if (head_dat.valid) begin
        regwrite_d = 1'b1;
        wreg_d     = head_dat.wreg;
        wdata_d    = head_dat.data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regwrite_q <= 1'b0;
      wreg_q     <= '0;
      wdata_q    <= '0;
    end else begin
      regwrite_q <= regwrite_d;
      wreg_q     <= wreg_d;
      wdata_q    <= wdata_d;
    end
  end

  assign RegWrite  = regwrite_q;
  assign WriteReg  = wreg_q;
  assign WriteData = wdata_q;

  // Oldest-to-youngest scan so the last FIFO hit wins; the output register overrides all.
  always_comb begin
    pend1 = 1'b0;
    pend2 = 1'b0;
    fwd1  = '0;
    fwd2  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (q_reg1 != '0 && ent_dat[i].valid && ent_dat[i].wreg == q_reg1) begin
        pend1 = 1'b1;
        fwd1  = ent_dat[i].data;
      end
      if (q_reg2 != '0 && ent_dat[i].valid && ent_dat[i].wreg == q_reg2) begin
        pend2 = 1'b1;
        fwd2  = ent_dat[i].data;
      end
    end
    if (q_reg1 != '0 && regwrite_q && wreg_q == q_reg1) begin
      pend1 = 1'b1;
      fwd1  = wdata_q;
    end
    if (q_reg2 != '0 && regwrite_q && wreg_q == q_reg2) begin
      pend2 = 1'b1;
      fwd2  = wdata_q;
    end
  end

`ifdef WB_FWD_EN
  assign fwd_data1 = fwd1;
  assign fwd_data2 = fwd2;
`else
  logic unused_fwd;
  assign unused_fwd = ^{fwd1, fwd2};
`endif
endmodule
